bcd_rounding: RTL and testbench



---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_inc.sv | 22 ++
 rtl/bcd_rounding.sv | 101 ++++++++++
 tb/tb_bcd_rounding.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD rounding block.
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ROUND_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit conditional increment; digits 9..15 with carry-in wrap to 0 and carry out.
import bcd_pkg::*;

module bcd_digit_inc (
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   cout
);
    always_comb begin
        digit_o = digit;
        cout    = 1'b0;
        if (cin) begin
            if (digit >= 4'd9) begin
                digit_o = '0;
                cout    = 1'b1;
            end else begin
                digit_o = digit + 4'd1;
            end
        end
    end
endmodule

// File: rtl/bcd_rounding.sv
// Rounds packed BCD to one fewer digit (half-up), rippling the carry one digit per clock.
// Build option BCD_ROUND_SAT_EN: overflow saturates to all 9s instead of wrapping to 0.
//
// state | meaning
// IDLE  | waiting for start; latches upper digits and the round-up carry
// CARRY | applies carry to digit idx_q, one digit per cycle
// DONE  | loads BCD_out (overflow adjusted) and raises done on the next cycle
import bcd_pkg::*;

module bcd_rounding #(
    parameter int DIGITS_IN = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [BCD_DIGIT_W*DIGITS_IN-1:0]     BCD_in,
    output logic [BCD_DIGIT_W*(DIGITS_IN-1)-1:0] BCD_out,
    output logic                                 done
);
    localparam int OUT_W = BCD_DIGIT_W * (DIGITS_IN - 1);
    localparam int IDX_W = $clog2(DIGITS_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS_IN - 2);

`ifdef BCD_ROUND_SAT_EN
    localparam logic [OUT_W-1:0] OVF_VAL = {(DIGITS_IN-1){4'h9}};
`else
    localparam logic [OUT_W-1:0] OVF_VAL = '0;
`endif

    state_t                   state_q, state_d;
    logic [OUT_W-1:0]         work_q;
    logic                     carry_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     start_ok;
    logic [BCD_DIGIT_W-1:0]   cur_digit;
    logic [BCD_DIGIT_W-1:0]   new_digit;
    logic                     new_carry;

    assign cur_digit = work_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];

    bcd_digit_inc u_inc (
        .digit   (cur_digit),
        .cin     (carry_q),
        .digit_o (new_digit),
        .cout    (new_carry)
    );

    // done is high during the first IDLE cycle after DONE; a start there is dropped.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done) begin
                    start_ok = 1'b1;
                    state_d  = CARRY;
                end
            end
            CARRY: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            BCD_out <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        work_q  <= BCD_in[BCD_DIGIT_W*DIGITS_IN-1:BCD_DIGIT_W];
                        carry_q <= (BCD_in[BCD_DIGIT_W-1:0] >= BCD_ROUND_THRESH);
                        idx_q   <= '0;
                    end
                end
                CARRY: begin
                    work_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] <= new_digit;
                    carry_q <= new_carry;
                    idx_q   <= idx_q + IDX_W'(1);
                end
                DONE: begin
                    BCD_out <= carry_q ? OVF_VAL : work_q;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_rounding.sv
// Directed table-driven bench for bcd_rounding plus busy/reset corner sequences.
module tb_bcd_rounding;
    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] BCD_in;
    logic [19:0] BCD_out;
    logic        done;

    int total = 0;
    int bad   = 0;

    bcd_rounding dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .BCD_in  (BCD_in),
        .BCD_out (BCD_out),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] din;
        logic [19:0] exp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and check latency, hold-during-op, result and pulse width.
    task automatic do_op(input logic [23:0] din, input logic [19:0] exp, input string name);
        int          lat;
        logic [19:0] prev;
        logic        hold_ok;
        lat     = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        prev   = BCD_out;
        BCD_in = din;
        start  = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (BCD_out !== prev) hold_ok = 1'b0;
        end
        chk({name, " latency"}, 32'(lat), 32'd7);
        chk({name, " hold"}, 32'(hold_ok), 32'd1);
        chk({name, " value"}, 32'(BCD_out), 32'(exp));
        @(posedge clk);
        #1;
        chk({name, " pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          ndone;
        int          first_lat;
        logic [19:0] kept;

        vecs[0]  = '{24'h123456, 20'h12346};
        vecs[1]  = '{24'h123454, 20'h12345};
        vecs[2]  = '{24'h123455, 20'h12346};
        vecs[3]  = '{24'h199995, 20'h20000};
        vecs[4]  = '{24'h999994, 20'h99999};
`ifdef BCD_ROUND_SAT_EN
        vecs[5]  = '{24'h999995, 20'h99999};
`else
        vecs[5]  = '{24'h999995, 20'h00000};
`endif
        vecs[6]  = '{24'h000004, 20'h00000};
        vecs[7]  = '{24'h000005, 20'h00001};
        vecs[8]  = '{24'h099995, 20'h10000};
        vecs[9]  = '{24'h12345F, 20'h12346};
        vecs[10] = '{24'h0000A5, 20'h00010};
        vecs[11] = '{24'h543219, 20'h54322};

        rst    = 1'b1;
        start  = 1'b0;
        BCD_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset BCD_out", 32'(BCD_out), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            do_op(vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Second start during an active op must be ignored.
        @(negedge clk);
        BCD_in = 24'h123456;
        start  = 1'b1;
        ndone     = 0;
        first_lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 3) begin
                BCD_in = 24'h999994;
                start  = 1'b1;
            end
            if (done) begin
                ndone++;
                if (first_lat == 0) first_lat = n;
                if (ndone == 1) chk("busy value", 32'(BCD_out), 32'h12346);
            end
        end
        chk("busy done count", 32'(ndone), 32'd1);
        chk("busy latency", 32'(first_lat), 32'd7);

        // Start presented in the done cycle must be ignored.
        @(negedge clk);
        BCD_in = 24'h123454;
        start  = 1'b1;
        first_lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                first_lat = n;
                break;
            end
        end
        chk("donecyc first latency", 32'(first_lat), 32'd7);
        kept   = BCD_out;
        BCD_in = 24'h555555;
        start  = 1'b1;
        ndone  = 0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) ndone++;
        end
        chk("donecyc ignored", 32'(ndone), 32'd0);
        chk("donecyc value", 32'(BCD_out), 32'(kept));
        chk("donecyc expected", 32'(BCD_out), 32'h12345);

        // Reset in the middle of CARRY aborts without a done.
        @(negedge clk);
        BCD_in = 24'h123456;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst BCD_out", 32'(BCD_out), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst no done", 32'(ndone), 32'd0);
        chk("midrst out held 0", 32'(BCD_out), 32'd0);

        do_op(24'h123454, 20'h12345, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
